seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed N-digit hex 7-segment display driver; successor to the single-digit combinational decoder.
//  Latches an N-nibble value and scans it onto shared segment lines, one anode at a time.
//  Inserts a blanking gap between digits against ghosting; sits between the datapath and board display pins.
// PARAMETERS
//  NUM_DIGITS    4      digits driven; >=1; digit 0 = least-significant nibble = rightmost
//  SCAN_DIV      50000  clock cycles per digit slot; >=2
//  BLANK_CYCLES  2      cycles at slot start with all anodes off; 0 <= BLANK_CYCLES < SCAN_DIV
//  SEG_ACT_LOW   0      1: invert seg outputs (common-anode board)
//  AN_ACT_LOW    0      1: invert an outputs
// PORTS
//  clk         in   1             rising-edge clock
//  reset       in   1             reset, synchronous, active-high
//  load        in   1             capture value/blank_mask into shadow registers this cycle
//  value       in   4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i]
//  blank_mask  in   NUM_DIGITS    1 = digit i forced dark (segments off, anode still scanned)
//  seg         out  [0:6]         segments a..g, seg[0]=a, active-high before SEG_ACT_LOW
//  an          out  NUM_DIGITS    one-hot anode select, active-high before AN_ACT_LOW
//  digit_idx   out  $clog2(NUM_DIGITS) (min 1)  index of the digit currently in its slot
// BEHAVIOUR
//  Reset: prescaler=0, digit_idx=0, shadow value=0, shadow mask=all 1s; seg and an at their inactive level (all off).
//  Reset mid-scan aborts the slot and takes effect on the next edge; load in the same cycle as reset is ignored.
//  Prescaler: counts 0..SCAN_DIV-1, then wraps to 0; at the wrap, digit_idx advances and wraps NUM_DIGITS-1 -> 0.
//  load: shadow registers update on that edge and never restart the scan.
//  A load mid-slot is visible in the next registered seg output; a new digit is never shown partially blanked.
//  Outputs: registered; seg/an reflect prescaler/digit_idx/shadow state of the previous cycle (1-cycle latency).
//  Blank window: prescaler < BLANK_CYCLES -> an = 0, seg = 0.
//  Otherwise: an = one-hot(digit_idx); seg = HEX_TO_SEG[nibble], or 0 if blank_mask bit is set.
//  HEX_TO_SEG (a..g):
//    0=1111110  1=0110000  2=1101101  3=1111001  4=0110011  5=1011011  6=1011111  7=1110000
//    8=1111111  9=1111011  A=1110111  b=0011111  C=1001110  d=0111101  E=1001111  F=1000111
//  Polarity inversion is applied after the output register; internal logic is always active-high.
//  NUM_DIGITS=1: digit_idx stays 0; an is 1 outside the blank window.
// CONFIGURATION
//  SEG7_LZ_SUPPRESS_EN defined:
//    - Leading zeros are dark: digit i is blanked if it and all higher nibbles are 0, for i>0.
//    - Digit 0 always shows (value 0 displays "0").
//    - Suppression is ORed with blank_mask and evaluated from the shadow value.
//  SEG7_LZ_SUPPRESS_EN undefined: all digits shown per blank_mask only; no suppression logic synthesised.
// STRUCTURE
//  Package seg7_pkg: seg7_t (logic [0:6]); SEG_OFF constant; HEX_TO_SEG 16-entry localparam table;
//  function hex_to_seg(logic [3:0]) -> seg7_t, shared with other display blocks.
//  Sub-module seg7_scan_timer: prescaler + digit_idx counter; outputs slot_tick and in_blank.
//  Top block holds the shadow registers, nibble mux, LZ logic and output registers.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, active-high unless noted)
//  1. Reset held 3 cycles, then released -> seg=0, an=0 during reset; digit_idx=0; first an=0001 two cycles after release.
//  2. load value=16'h12AF, mask=0 -> per 4-cycle slot: 1 cycle an=0, then 3 cycles of each digit:
//     an=0001 seg=1000111; an=0010 seg=1110111; an=0100 seg=1101101; an=1000 seg=0110000; then repeats.
//  3. load mid-slot (prescaler=2) value 16'h0008 -> next seg=1111111; digit_idx not disturbed.
//  4. blank_mask=4'b0100 with value 16'h8888 -> digit 2 slot: an=0100, seg=0000000; others 1111111.
//  5. SEG7_LZ_SUPPRESS_EN, value=16'h0050 -> digits 3,2 dark, digit 1 shows 1011011 (5), digit 0 shows 1111110 (0);
//     value=0 -> only digit 0 lit with 1111110.
//  6. SEG_ACT_LOW=1, AN_ACT_LOW=1 -> reset yields seg=7'b1111111, an=4'b1111; digit "1" drives seg=1001111.
//     Reset asserted mid-slot -> outputs off next edge, scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment types and the hex glyph table used by the display blocks.
package seg7_pkg;

  typedef logic [0:6] seg7_t;  // seg[0] = a ... seg[6] = g

  localparam seg7_t SEG_OFF = 7'b0000000;

  localparam seg7_t HEX_TO_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic seg7_t hex_to_seg(input logic [3:0] nib);
    return HEX_TO_SEG[nib];
  endfunction

  // Width of a digit index; a single-digit display still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot prescaler and digit counter for the multiplexed display scan.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 2,
  localparam int unsigned DIGIT_W     = idx_width(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               slot_tick,
  output logic               in_blank,
  output logic [DIGIT_W-1:0] digit_idx
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;

  assign slot_tick = (cnt_q == CntW'(SCAN_DIV - 1));
  assign in_blank  = (32'(cnt_q) < BLANK_CYCLES);
  assign digit_idx = digit_q;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (slot_tick) begin
      cnt_d   = '0;
      digit_d = (digit_q == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with inter-digit blanking.
// Define SEG7_LZ_SUPPRESS_EN to darken leading zeros (digit 0 always lit).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          SEG_ACT_LOW  = 1'b0,
  parameter bit          AN_ACT_LOW   = 1'b0,
  localparam int unsigned DIGIT_W     = idx_width(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output seg7_t                   seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [DIGIT_W-1:0]      digit_idx
);

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [NUM_DIGITS-1:0]   dark;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg7_t                   seg_q, seg_d;
  logic [3:0]              nib;
  logic                    dark_sel;
  logic                    in_blank;
  // Slot boundaries are already implied by in_blank; the tick is for other consumers.
  logic                    unused_slot_tick;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .slot_tick(unused_slot_tick),
    .in_blank (in_blank),
    .digit_idx(digit_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      mask_q  <= '1;
    end else if (load) begin
      value_q <= value;
      mask_q  <= blank_mask;
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz;

  // Walk down from the top nibble; a digit is a leading zero while everything above is zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz         = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (value_q[4*i +: 4] == 4'h0);
      lz[i]      = upper_zero & (i > 0);
    end
  end

  assign dark = mask_q | lz;
`else
  assign dark = mask_q;
`endif

  always_comb begin
    nib      = 4'h0;
    dark_sel = 1'b0;
    an_d     = '0;
    seg_d    = SEG_OFF;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == DIGIT_W'(i)) begin
        nib      = value_q[4*i +: 4];
        dark_sel = dark[i];
        an_d[i]  = 1'b1;
      end
    end
    if (in_blank) begin
      an_d = '0;
    end else if (!dark_sel) begin
      seg_d = hex_to_seg(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_OFF;
      an_q  <= '0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = SEG_ACT_LOW ? ~seg_q : seg_q;
  assign an  = AN_ACT_LOW ? ~an_q : an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: active-high and active-low drivers share stimulus and expectations.
module tb_seg7_scan_driver;

  typedef logic [0:6] seg_t;
  typedef struct {
    int         cyc;
    seg_t       seg;
    logic [3:0] an;
    logic [1:0] didx;
  } exp_t;

`ifdef SEG7_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam seg_t S0   = 7'b1111110;
  localparam seg_t S1   = 7'b0110000;
  localparam seg_t S2   = 7'b1101101;
  localparam seg_t S5   = 7'b1011011;
  localparam seg_t S8   = 7'b1111111;
  localparam seg_t SA   = 7'b1110111;
  localparam seg_t SF   = 7'b1000111;
  localparam seg_t SOFF = 7'b0000000;
  // A zero nibble above the highest nonzero one: dark only with suppression.
  localparam seg_t SZ   = LZ ? SOFF : S0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  seg_t        seg, seg_n;
  logic [3:0]  an, an_n;
  logic [1:0]  didx, didx_n;

  exp_t q[$];
  int   cyc = 0;
  int   rb = 0;
  int   from_edge = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_mask(blank_mask),
    .seg(seg), .an(an), .digit_idx(didx)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut_n (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_mask(blank_mask),
    .seg(seg_n), .an(an_n), .digit_idx(didx_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int e, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %b want %b", nm, e, got, want);
    end
  endtask

  task automatic push_cycle(input int e, input seg_t s, input logic [3:0] a, input int d);
    exp_t x;
    if (e < from_edge) return;
    x.cyc  = e;
    x.seg  = s;
    x.an   = a;
    x.didx = 2'(d % 4);
    q.push_back(x);
  endtask

  // Slot m after scan start rb: one blank edge, then three lit edges of digit m%4.
  task automatic push_slot(input int m, input seg_t s);
    logic [3:0] a;
    int         b;
    a = 4'(1 << (m % 4));
    b = rb + 4 * m;
    push_cycle(b + 1, SOFF, 4'b0000, m);
    push_cycle(b + 2, s, a, m);
    push_cycle(b + 3, s, a, m);
    push_cycle(b + 4, s, a, m + 1);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      x = q.pop_front();
      if (x.cyc != cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL missed edge: got %0d want %0d", cyc, x.cyc);
      end else begin
        chk("seg", cyc, {9'b0, seg}, {9'b0, x.seg});
        chk("an", cyc, {12'b0, an}, {12'b0, x.an});
        chk("digit_idx", cyc, {14'b0, didx}, {14'b0, x.didx});
        chk("seg_low", cyc, {9'b0, seg_n}, {9'b0, ~x.seg});
        chk("an_low", cyc, {12'b0, an_n}, {12'b0, ~x.an});
      end
    end
  end

  initial begin
    // Reset for edges 1..3, off throughout; first lit anode at edge 5 (mask still all ones).
    for (int e = 1; e <= 3; e++) push_cycle(e, SOFF, 4'b0000, 0);
    rb = 3;
    push_cycle(4, SOFF, 4'b0000, 0);
    push_cycle(5, SOFF, 4'b0001, 0);
    wait_edge(3);
    reset = 1'b0;

    // Plain scan of 12AF.
    wait_edge(5);
    value = 16'h12AF; blank_mask = 4'b0000; load = 1'b1;
    push_slot(4, SF); push_slot(5, SA); push_slot(6, S2); push_slot(7, S1);
    wait_edge(6);
    load = 1'b0;

    // Load at prescaler=2 of digit 0: old glyph once more, then the new one.
    wait_edge(37);
    value = 16'h0008; load = 1'b1;
    from_edge = 38;
    push_cycle(38, SF, 4'b0001, 0);
    from_edge = 39;
    push_slot(8, S8); push_slot(9, SZ); push_slot(10, SZ); push_slot(11, SZ);
    wait_edge(38);
    load = 1'b0;

    // Digit 2 masked: anode still scanned, segments dark.
    wait_edge(51);
    value = 16'h8888; blank_mask = 4'b0100; load = 1'b1;
    from_edge = 52;
    push_slot(12, S8); push_slot(13, S8); push_slot(14, SOFF); push_slot(15, S8);
    wait_edge(52);
    load = 1'b0;

    wait_edge(67);
    value = 16'h0050; blank_mask = 4'b0000; load = 1'b1;
    from_edge = 68;
    push_slot(16, S0); push_slot(17, S5); push_slot(18, SZ); push_slot(19, SZ);
    wait_edge(68);
    load = 1'b0;

    wait_edge(83);
    value = 16'h0000; load = 1'b1;
    from_edge = 84;
    push_slot(20, S0); push_slot(21, SZ); push_slot(22, SZ); push_slot(23, SZ);
    wait_edge(84);
    load = 1'b0;

    // Reset mid-slot with a simultaneous load that must be dropped.
    wait_edge(101);
    reset = 1'b1; load = 1'b1; value = 16'hFFFF; blank_mask = 4'b0000;
    from_edge = 102;
    push_cycle(102, SOFF, 4'b0000, 0);
    wait_edge(102);
    reset = 1'b0; load = 1'b0;
    rb = 102;
    from_edge = 103;
    push_slot(0, SOFF); push_slot(1, SOFF);

    wait_edge(110);
    value = 16'h0001; blank_mask = 4'b0000; load = 1'b1;
    from_edge = 111;
    push_slot(2, SZ); push_slot(3, SZ); push_slot(4, S1);
    wait_edge(111);
    load = 1'b0;

    wait_edge(130);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL pending: got %0d entries left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
